bloco_operacional: RTL and testbench

BLOCO_OPERACIONAL -- requirements
Module: bloco_operacional

---
 rtl/bloco_operacional_pkg.sv | 26 ++
 rtl/bloco_operacional_banco_registradores.sv | 39 +++
 rtl/bloco_operacional.sv | 110 +++++++++++
 tb/tb_bloco_operacional.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bloco_operacional_pkg.sv
// Shared definitions for the bloco_operacional datapath: default sizes and
// the encodings of the write-source and ALU-operation selects.
package bloco_operacional_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int NREGS_DEF  = 16;

   typedef enum logic [1:0] {
      SRC_ALU   = 2'b00,
      SRC_MEM   = 2'b01,
      SRC_CONST = 2'b10,
      SRC_NONE  = 2'b11
   } wsrc_t;

   typedef enum logic [1:0] {
      OP_PASS_P = 2'b00,
      OP_ADD    = 2'b01,
      OP_SUB    = 2'b10,
      OP_PASS_Q = 2'b11
   } alu_op_t;

   function automatic int addr_width(input int nregs);
      return (nregs > 1) ? $clog2(nregs) : 1;
   endfunction

endpackage

// File: rtl/bloco_operacional_banco_registradores.sv
// Register file with one synchronous write port and two combinational read
// ports; reads see the stored value, never the word being written this cycle.
module banco_registradores
   import bloco_operacional_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int NREGS  = NREGS_DEF,
   parameter int AW     = addr_width(NREGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [AW-1:0]     w_addr,
   input  logic [DATA_W-1:0] w_data,
   input  logic              w_en,
   input  logic [AW-1:0]     p_addr,
   input  logic              p_rd,
   output logic [DATA_W-1:0] p_data,
   input  logic [AW-1:0]     q_addr,
   input  logic              q_rd,
   output logic [DATA_W-1:0] q_data
);

   logic [DATA_W-1:0] regs [NREGS];

   // Reset wins over a write presented on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (w_en) begin
         regs[w_addr] <= w_data;
      end
   end

   assign p_data = p_rd ? regs[p_addr] : '0;
   assign q_data = q_rd ? regs[q_addr] : '0;

endmodule

// File: rtl/bloco_operacional.sv
// Datapath: register file, write-source mux, ALU and Rp zero detect.
// Define BLOCO_OPERACIONAL_FLAGS_EN to build the registered carry/borrow flag.
module bloco_operacional
   import bloco_operacional_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int NREGS  = NREGS_DEF
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [DATA_W-1:0]             RF_W_data,
   input  logic                          RF_s1,
   input  logic                          RF_s0,
   input  logic [addr_width(NREGS)-1:0]  RF_W_addr,
   input  logic [addr_width(NREGS)-1:0]  RF_Rp_addr,
   input  logic [addr_width(NREGS)-1:0]  RF_Rq_addr,
   input  logic                          RF_W_wr,
   input  logic                          RF_Rp_rd,
   input  logic                          RF_Rq_rd,
   input  logic                          alu_s1,
   input  logic                          alu_s0,
   output logic                          RF_Rp_zero,
   input  logic [DATA_W-1:0]             D_R_data,
   output logic [DATA_W-1:0]             D_W_data,
   output logic                          alu_c
);

   localparam int AW = addr_width(NREGS);

   wsrc_t             src;
   alu_op_t           op;
   logic [DATA_W-1:0] rp_data;
   logic [DATA_W-1:0] rq_data;
   logic [DATA_W-1:0] alu_result;
   logic [DATA_W-1:0] w_data;
   logic              write_en;

   assign src = wsrc_t'({RF_s1, RF_s0});
   assign op  = alu_op_t'({alu_s1, alu_s0});

   // The NONE source turns a requested write into a no-op.
   assign write_en = RF_W_wr && (src != SRC_NONE);

   banco_registradores #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .AW     (AW)
   ) u_banco (
      .clk    (clk),
      .reset  (reset),
      .w_addr (RF_W_addr),
      .w_data (w_data),
      .w_en   (write_en),
      .p_addr (RF_Rp_addr),
      .p_rd   (RF_Rp_rd),
      .p_data (rp_data),
      .q_addr (RF_Rq_addr),
      .q_rd   (RF_Rq_rd),
      .q_data (rq_data)
   );

   always_comb begin
      alu_result = rp_data;
      case (op)
         OP_PASS_P: alu_result = rp_data;
         OP_ADD:    alu_result = rp_data + rq_data;
         OP_SUB:    alu_result = rp_data - rq_data;
         OP_PASS_Q: alu_result = rq_data;
         default:   alu_result = rp_data;
      endcase
   end

   always_comb begin
      w_data = alu_result;
      case (src)
         SRC_ALU:   w_data = alu_result;
         SRC_MEM:   w_data = D_R_data;
         SRC_CONST: w_data = RF_W_data;
         default:   w_data = alu_result;
      endcase
   end

   assign D_W_data   = rp_data;
   assign RF_Rp_zero = RF_Rp_rd && (rp_data == '0);

`ifdef BLOCO_OPERACIONAL_FLAGS_EN
   logic [DATA_W:0] add_ext;
   logic            flag_q;

   assign add_ext = {1'b0, rp_data} + {1'b0, rq_data};

   // Only committed ALU writes of ADD/SUB update the flag; pass ops hold it.
   always_ff @(posedge clk) begin
      if (reset) begin
         flag_q <= 1'b0;
      end else if (write_en && (src == SRC_ALU)) begin
         if (op == OP_ADD) begin
            flag_q <= add_ext[DATA_W];
         end else if (op == OP_SUB) begin
            flag_q <= (rp_data < rq_data);
         end
      end
   end

   assign alu_c = flag_q;
`else
   assign alu_c = 1'b0;
`endif

endmodule

// File: tb/tb_bloco_operacional.sv
// Table-driven bench for bloco_operacional with an expected-value queue.
// Expected flag values are masked when BLOCO_OPERACIONAL_FLAGS_EN is undefined.
module tb_bloco_operacional;

`ifdef BLOCO_OPERACIONAL_FLAGS_EN
   localparam logic FLAGS = 1'b1;
`else
   localparam logic FLAGS = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] RF_W_data;
   logic       RF_s1, RF_s0;
   logic [3:0] RF_W_addr, RF_Rp_addr, RF_Rq_addr;
   logic       RF_W_wr, RF_Rp_rd, RF_Rq_rd;
   logic       alu_s1, alu_s0;
   logic       RF_Rp_zero;
   logic [7:0] D_R_data;
   logic [7:0] D_W_data;
   logic       alu_c;

   bloco_operacional #(.DATA_W(8), .NREGS(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .RF_W_data  (RF_W_data),
      .RF_s1      (RF_s1),
      .RF_s0      (RF_s0),
      .RF_W_addr  (RF_W_addr),
      .RF_Rp_addr (RF_Rp_addr),
      .RF_Rq_addr (RF_Rq_addr),
      .RF_W_wr    (RF_W_wr),
      .RF_Rp_rd   (RF_Rp_rd),
      .RF_Rq_rd   (RF_Rq_rd),
      .alu_s1     (alu_s1),
      .alu_s0     (alu_s0),
      .RF_Rp_zero (RF_Rp_zero),
      .D_R_data   (D_R_data),
      .D_W_data   (D_W_data),
      .alu_c      (alu_c)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [1:0] sel;
      logic       wr;
      logic [3:0] waddr;
      logic [7:0] wdata;
      logic [7:0] mem;
      logic [1:0] alu;
      logic       prd;
      logic [3:0] paddr;
      logic       qrd;
      logic [3:0] qaddr;
      logic [7:0] dw;
      logic       zero;
      logic       c;
   } vec_t;

   typedef struct {
      int         idx;
      logic [7:0] dw;
      logic       zero;
      logic       c;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic add_vec(input logic rst, input logic [1:0] sel, input logic wr,
                          input logic [3:0] waddr, input logic [7:0] wdata,
                          input logic [7:0] mem, input logic [1:0] alu,
                          input logic prd, input logic [3:0] paddr,
                          input logic qrd, input logic [3:0] qaddr,
                          input logic [7:0] dw, input logic zero, input logic c);
      vec_t t;
      t.rst = rst;   t.sel = sel;     t.wr = wr;     t.waddr = waddr;
      t.wdata = wdata; t.mem = mem;   t.alu = alu;
      t.prd = prd;   t.paddr = paddr; t.qrd = qrd;   t.qaddr = qaddr;
      t.dw = dw;     t.zero = zero;   t.c = c;
      vecs.push_back(t);
   endtask

   task automatic applyStimulus(input vec_t t, input int idx);
      exp_t e;
      reset      = t.rst;
      {RF_s1, RF_s0} = t.sel;
      RF_W_wr    = t.wr;
      RF_W_addr  = t.waddr;
      RF_W_data  = t.wdata;
      D_R_data   = t.mem;
      {alu_s1, alu_s0} = t.alu;
      RF_Rp_rd   = t.prd;
      RF_Rp_addr = t.paddr;
      RF_Rq_rd   = t.qrd;
      RF_Rq_addr = t.qaddr;
      e.idx  = idx;
      e.dw   = t.dw;
      e.zero = t.zero;
      e.c    = t.c & FLAGS;
      sb.push_back(e);
   endtask

   task automatic compare(input string name, input int idx,
                          input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s vec %0d: got 0x%02h expected 0x%02h", name, idx, act, exp);
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard: got empty queue expected an entry");
         return;
      end
      e = sb.pop_front();
      compare("D_W_data",   e.idx, D_W_data,          e.dw);
      compare("RF_Rp_zero", e.idx, {7'd0, RF_Rp_zero}, {7'd0, e.zero});
      compare("alu_c",      e.idx, {7'd0, alu_c},      {7'd0, e.c});
   endtask

   initial begin
      reset = 1'b1;
      {RF_s1, RF_s0} = 2'b11;
      RF_W_wr = 1'b0; RF_W_addr = '0; RF_W_data = '0; D_R_data = '0;
      {alu_s1, alu_s0} = 2'b00;
      RF_Rp_rd = 1'b0; RF_Rp_addr = '0; RF_Rq_rd = 1'b0; RF_Rq_addr = '0;
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Post-reset sweep: every register reads zero, zero flag set.
      for (int i = 0; i < 16; i++) begin
         add_vec(0, 2'b11, 0, 4'd0, 8'h00, 8'h00, 2'b00, 1, 4'(i), 0, 4'd0, 8'h00, 1, 0);
      end
      // rd disabled: data 0 and zero flag 0
      add_vec(0, 2'b11, 0, 4'd0, 8'h00, 8'h00, 2'b00, 0, 4'd3, 0, 4'd0, 8'h00, 0, 0);
      // MOVC R3=2A while reading R3 (old value), then read
      add_vec(0, 2'b10, 1, 4'd3, 8'h2A, 8'h00, 2'b00, 1, 4'd3, 0, 4'd0, 8'h00, 1, 0);
      add_vec(0, 2'b11, 0, 4'd0, 8'h00, 8'h00, 2'b00, 1, 4'd3, 0, 4'd0, 8'h2A, 0, 0);
      // R1=F0, R2=20
      add_vec(0, 2'b10, 1, 4'd1, 8'hF0, 8'h00, 2'b00, 0, 4'd0, 0, 4'd0, 8'h00, 0, 0);
      add_vec(0, 2'b10, 1, 4'd2, 8'h20, 8'h00, 2'b00, 1, 4'd1, 0, 4'd0, 8'hF0, 0, 0);
      // ADD R4=R1+R2 wraps to 10 with carry
      add_vec(0, 2'b00, 1, 4'd4, 8'h00, 8'h00, 2'b01, 1, 4'd1, 1, 4'd2, 8'hF0, 0, 0);
      add_vec(0, 2'b11, 0, 4'd0, 8'h00, 8'h00, 2'b00, 1, 4'd4, 0, 4'd0, 8'h10, 0, 1);
      // MOVR R5=7F holds the flag; SUB R6=R5-R5 clears it
      add_vec(0, 2'b01, 1, 4'd5, 8'h00, 8'h7F, 2'b00, 0, 4'd0, 0, 4'd0, 8'h00, 0, 1);
      add_vec(0, 2'b00, 1, 4'd6, 8'h00, 8'h00, 2'b10, 1, 4'd5, 1, 4'd5, 8'h7F, 0, 1);
      add_vec(0, 2'b11, 0, 4'd0, 8'h00, 8'h00, 2'b00, 1, 4'd6, 0, 4'd0, 8'h00, 1, 0);
      // SUB R8=R2-R1 = 30 with borrow
      add_vec(0, 2'b00, 1, 4'd8, 8'h00, 8'h00, 2'b10, 1, 4'd2, 1, 4'd1, 8'h20, 0, 0);
      add_vec(0, 2'b11, 0, 4'd0, 8'h00, 8'h00, 2'b00, 1, 4'd8, 0, 4'd0, 8'h30, 0, 1);
      // PASS_Q R9=R3 keeps the flag
      add_vec(0, 2'b00, 1, 4'd9, 8'h00, 8'h00, 2'b11, 0, 4'd0, 1, 4'd3, 8'h00, 0, 1);
      add_vec(0, 2'b11, 0, 4'd0, 8'h00, 8'h00, 2'b00, 1, 4'd9, 0, 4'd0, 8'h2A, 0, 1);
      // R7=55 while reading R7, then suppressed write (sel 11), then read
      add_vec(0, 2'b10, 1, 4'd7, 8'h55, 8'h00, 2'b00, 1, 4'd7, 0, 4'd0, 8'h00, 1, 1);
      add_vec(0, 2'b11, 1, 4'd7, 8'hAA, 8'h00, 2'b00, 1, 4'd7, 0, 4'd0, 8'h55, 0, 1);
      add_vec(0, 2'b11, 0, 4'd0, 8'h00, 8'h00, 2'b00, 1, 4'd7, 0, 4'd0, 8'h55, 0, 1);
      // PASS_P with Rp and Rq on the same address
      add_vec(0, 2'b00, 1, 4'd10, 8'h00, 8'h00, 2'b00, 1, 4'd3, 1, 4'd3, 8'h2A, 0, 1);
      add_vec(0, 2'b11, 0, 4'd0, 8'h00, 8'h00, 2'b00, 1, 4'd10, 0, 4'd0, 8'h2A, 0, 1);
      // ADD without carry clears the flag: R11=2A+10
      add_vec(0, 2'b00, 1, 4'd11, 8'h00, 8'h00, 2'b01, 1, 4'd3, 1, 4'd4, 8'h2A, 0, 1);
      add_vec(0, 2'b11, 0, 4'd0, 8'h00, 8'h00, 2'b00, 1, 4'd11, 0, 4'd0, 8'h3A, 0, 0);
      // ADD with Rq disabled adds zero: R12=2A
      add_vec(0, 2'b00, 1, 4'd12, 8'h00, 8'h00, 2'b01, 1, 4'd3, 0, 4'd4, 8'h2A, 0, 0);
      add_vec(0, 2'b11, 0, 4'd0, 8'h00, 8'h00, 2'b00, 1, 4'd12, 0, 4'd0, 8'h2A, 0, 0);
      // Set the flag again so reset has something to clear
      add_vec(0, 2'b00, 1, 4'd13, 8'h00, 8'h00, 2'b01, 1, 4'd1, 1, 4'd1, 8'hF0, 0, 0);
      // Reset with a concurrent MOVC to R2: write discarded
      add_vec(1, 2'b10, 1, 4'd2, 8'h99, 8'h00, 2'b00, 1, 4'd2, 0, 4'd0, 8'h20, 0, 1);
      add_vec(0, 2'b11, 0, 4'd0, 8'h00, 8'h00, 2'b00, 1, 4'd2, 0, 4'd0, 8'h00, 1, 0);
      add_vec(0, 2'b11, 0, 4'd0, 8'h00, 8'h00, 2'b00, 1, 4'd3, 0, 4'd0, 8'h00, 1, 0);
      add_vec(0, 2'b11, 0, 4'd0, 8'h00, 8'h00, 2'b00, 1, 4'd13, 0, 4'd0, 8'h00, 1, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i], i);
         @(negedge clk);
         checkOutput();
         @(posedge clk);
         #1;
      end

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard drain: got %0d leftover expected 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
